// File: rtl/mux_n_pipe.sv
// N-way registered multiplexer with a 2-entry head/skid output buffer.
// The selected input is captured on accept; out-of-range selects clamp to the last input.
module mux_n_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = (NUM_IN < 2) ? 1 : $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] inputs,
  input  logic [SEL_W-1:0]        select,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [1:0]              occ
);

  localparam logic [SEL_W:0]   NumInW   = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LastSel  = SEL_W'(NUM_IN - 1);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   head_data_q;
  logic               head_err_q;
  logic [WIDTH-1:0]   skid_data_q;
  logic               skid_err_q;

  logic               cap_err;
  logic [SEL_W-1:0]   cap_sel;
  logic [WIDTH-1:0]   cap_data;
  logic               accept;
  logic               pop;

  // Clamp the select before muxing so NUM_IN that is not a power of two stays safe.
  always_comb begin
    cap_err  = ({1'b0, select} >= NumInW);
    cap_sel  = cap_err ? LastSel : select;
    cap_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (cap_sel == SEL_W'(k)) begin
        cap_data = inputs[k*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake status comes only from registered state, so in_ready never sees out_ready.
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    unique case (state_q)
      StEmpty: occ = 2'd0;
      StOne:   occ = 2'd1;
      StFull:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    result  = head_data_q;
    sel_err = head_err_q;
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_data_q <= cap_data;
            head_err_q  <= cap_err;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_data_q <= cap_data;
            head_err_q  <= cap_err;
          end else if (accept) begin
            skid_data_q <= cap_data;
            skid_err_q  <= cap_err;
            state_q     <= StFull;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop) begin
            head_data_q <= skid_data_q;
            head_err_q  <= skid_err_q;
            state_q     <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed and randomized-streaming bench for mux_n_pipe (NUM_IN=4 and NUM_IN=3 instances).
module tb_mux_n_pipe;

  logic         clk;
  logic         reset;
  logic [127:0] inputs;
  logic [1:0]   select;
  logic         in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [31:0]  result;
  logic [1:0]   occ;

  logic [95:0]  inputs3;
  logic [1:0]   select3;
  logic         in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
  logic [31:0]  result3;
  logic [1:0]   occ3;

  int n_cmp = 0;
  int n_err = 0;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .reset(reset), .inputs(inputs), .select(select), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .result(result), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .occ(occ)
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .inputs(inputs3), .select(select3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush3), .result(result3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3), .occ(occ3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_rdy: got %b want 1", in_ready); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
    n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL rst_selerr: got %b want 0", sel_err); end
    // Offers while in reset must be ignored.
    in_valid = 1'b1;
    inputs   = {32'h4, 32'h3, 32'h2, 32'h1};
    tick();
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL rst_noaccept: occ got %0d want 0", occ); end
    in_valid = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_basic_select();
    inputs    = {32'h44, 32'h33, 32'h22, 32'h11};
    select    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'h33) begin n_err++; $display("FAIL basic_result: got %h want 33", result); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_vld: got %b want 1", out_valid); end
    n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL basic_selerr: got %b want 0", sel_err); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [3];
    logic [1:0]  occ_exp [3];
    vals    = '{32'hA, 32'hB, 32'hC};
    occ_exp = '{2'd1, 2'd2, 2'd2};
    out_ready = 1'b0;
    select    = 2'd1;
    inputs    = '0;
    for (int i = 0; i < 3; i++) begin
      inputs[32 +: 32] = vals[i];
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== (i < 2)) begin
        n_err++; $display("FAIL bp_rdy%0d: got %b want %b", i, in_ready, (i < 2));
      end
      tick();
      n_cmp++;
      if (occ !== occ_exp[i]) begin
        n_err++; $display("FAIL bp_occ%0d: got %0d want %0d", i, occ, occ_exp[i]);
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'hA) begin n_err++; $display("FAIL bp_headA: got %h want a", result); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (result !== 32'hB) begin n_err++; $display("FAIL bp_headB: got %h want b", result); end
    n_cmp++; if (occ !== 2'd1) begin n_err++; $display("FAIL bp_occB: got %0d want 1", occ); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_noC: got %b want 0", out_valid); end
  endtask

  task automatic test_out_of_range();
    inputs3    = {32'h300, 32'h200, 32'h100};
    select3    = 2'd3;
    in_valid3  = 1'b1;
    out_ready3 = 1'b0;
    tick();
    n_cmp++; if (result3 !== 32'h300) begin n_err++; $display("FAIL oor_result: got %h want 300", result3); end
    n_cmp++; if (sel_err3 !== 1'b1) begin n_err++; $display("FAIL oor_selerr: got %b want 1", sel_err3); end
    select3 = 2'd1;
    tick();
    in_valid3 = 1'b0;
    n_cmp++; if (result3 !== 32'h300 || sel_err3 !== 1'b1) begin
      n_err++; $display("FAIL oor_hold: got %h/%b want 300/1", result3, sel_err3);
    end
    out_ready3 = 1'b1;
    tick();
    n_cmp++; if (result3 !== 32'h200) begin n_err++; $display("FAIL oor_next: got %h want 200", result3); end
    n_cmp++; if (sel_err3 !== 1'b0) begin n_err++; $display("FAIL oor_next_err: got %b want 0", sel_err3); end
    tick();
    n_cmp++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL oor_drain: got %b want 0", out_valid3); end
  endtask

  task automatic test_flush_priority();
    inputs    = {32'h4, 32'h3, 32'h2, 32'h77};
    select    = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL fl_full: got %0d want 2", occ); end
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL fl_occ: got %0d want 0", occ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_vld: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_rdy: got %b want 1", in_ready); end
    inputs[31:0] = 32'h99;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (result !== 32'h99) begin n_err++; $display("FAIL fl_after: got %h want 99", result); end
    tick();
  endtask

  task automatic test_async_reset();
    inputs    = {32'h4, 32'h3, 32'h2, 32'h5A5A};
    select    = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd2 || result !== 32'h5A5A) begin
      n_err++; $display("FAIL ar_pre: got occ %0d res %h want 2/5a5a", occ, result);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL ar_occ: got %0d want 0", occ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_vld: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL ar_result: got %h want 0", result); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ar_rdy: got %b want 1", in_ready); end
    #2 reset = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic [31:0] q[$];
    int          acc_cnt;
    int          cycles;
    int          stalls;
    logic        prev_ordy;
    logic        acc, pop;
    acc_cnt   = 0;
    cycles    = 0;
    stalls    = 0;
    prev_ordy = 1'b0;
    while ((acc_cnt < 100 || q.size() != 0) && cycles < 2000) begin
      in_valid = (acc_cnt < 100);
      for (int k = 0; k < 4; k++) inputs[k*32 +: 32] = $urandom;
      select    = 2'($urandom_range(0, 3));
      out_ready = (acc_cnt >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      n_cmp++;
      if (in_ready !== (q.size() < 2)) begin
        n_err++; $display("FAIL st_rdy: got %b want %b", in_ready, (q.size() < 2));
      end
      if (prev_ordy && in_valid && !in_ready) stalls++;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        n_cmp++;
        if (q.size() == 0 || result !== q[0]) begin
          n_err++; $display("FAIL st_data: got %h want %h", result, (q.size() != 0) ? q[0] : 32'h0);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(inputs[select*32 +: 32]);
        acc_cnt++;
      end
      prev_ordy = out_ready;
      tick();
      cycles++;
      n_cmp++;
      if (occ !== 2'(q.size()) || out_valid !== (q.size() != 0)) begin
        n_err++; $display("FAIL st_occ: got %0d/%b want %0d", occ, out_valid, q.size());
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (cycles >= 2000) begin n_err++; $display("FAIL st_timeout: got %0d cycles want < 2000", cycles); end
    n_cmp++; if (acc_cnt !== 100) begin n_err++; $display("FAIL st_count: got %0d want 100", acc_cnt); end
    n_cmp++; if (stalls !== 0) begin n_err++; $display("FAIL st_throughput: got %0d stalls want 0", stalls); end
  endtask

  initial begin
    inputs = '0; select = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    inputs3 = '0; select3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
    test_reset();
    test_basic_select();
    test_backpressure();
    test_out_of_range();
    test_flush_priority();
    test_async_reset();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each input and of RESULT.
REQ-002 SHALL have parameter NUM_IN, default 4, number of selectable inputs, legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = clog2(NUM_IN), with a minimum of 1.
REQ-004 SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port INPUTS  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port SELECT  in  SEL_W  input index, sampled with IN_VALID.
REQ-008 SHALL have port IN_VALID  in  1  upstream offers INPUTS/SELECT this cycle.
REQ-009 SHALL have port IN_READY  out  1  block accepts an offer this cycle.
REQ-010 SHALL have port FLUSH  in  1  synchronous discard of all held entries.
REQ-011 SHALL have port RESULT  out  WIDTH  selected data of the head entry.
REQ-012 SHALL have port OUT_VALID  out  1  RESULT holds a valid entry.
REQ-013 SHALL have port OUT_READY  in  1  downstream consumes the head entry this cycle.
REQ-014 SHALL have port SEL_ERR  out  1  head entry was captured with an out-of-range SELECT.
REQ-015 SHALL have port OCC  out  2  number of held entries (0..2).

Function
REQ-016 SHALL perform an accept when IN_VALID && IN_READY, and a pop when OUT_VALID && OUT_READY.
REQ-017 SHALL, on accept, capture INPUTS[SELECT] together with the error flag; SELECT >= NUM_IN SHALL capture input NUM_IN-1 with the flag set to 1.
REQ-018 SHALL provide latency of exactly 1 cycle: an entry accepted at edge n appears on RESULT/OUT_VALID after edge n when the block was empty.
REQ-019 SHALL use a 2-entry buffer of HEAD (drives outputs) and SKID, with states EMPTY (OCC=0), ONE (OCC=1) and FULL (OCC=2).
REQ-020 SHALL drive IN_READY = (state != FULL), taken from registered state only with no combinational path from OUT_READY.
REQ-021 SHALL apply transitions per edge, with FLUSH=0: EMPTY+accept -> ONE; ONE+accept+no pop -> FULL (data into SKID); ONE+accept+pop -> ONE (new data into HEAD); ONE+pop -> EMPTY; FULL+pop -> ONE (SKID moves to HEAD); all other combinations hold.
REQ-022 SHALL preserve order: entries leave in acceptance order, with none lost or duplicated.
REQ-023 SHALL hold RESULT/SEL_ERR stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 SHALL give FLUSH=1 priority over accept and pop in the same cycle: next state EMPTY, no entry captured, with IN_READY=1 on the following cycle.
REQ-025 SHALL keep RESULT and SEL_ERR at their last values when OUT_VALID=0; these values are don't-care for checking but SHALL not be X after reset.
REQ-026 SHALL behave identically for every NUM_IN in range, including non-power-of-two values such as NUM_IN=3, where SELECT=3 is out of range.

Reset
REQ-027 SHALL, on RESET=0, immediately and independently of CLK force state EMPTY, OCC=0, OUT_VALID=0, IN_READY=1, RESULT=0 and SEL_ERR=0.
REQ-028 SHALL discard held entries when reset is asserted mid-operation, and SHALL accept nothing while RESET=0.
REQ-029 SHALL allow the first accept on the first rising edge after RESET deasserts.

Verification
REQ-030 SHALL cover basic select: WIDTH=32, NUM_IN=4, inputs 0x11,0x22,0x33,0x44, SELECT=2, IN_VALID=1, OUT_READY=1 -> next cycle RESULT=0x33, OUT_VALID=1, SEL_ERR=0.
REQ-031 SHALL cover backpressure: OUT_READY=0 with 3 consecutive offers A,B,C -> OCC 1,2,2, IN_READY=0 at third offer, C not accepted; then OUT_READY=1 -> RESULT A then B.
REQ-032 SHALL cover out-of-range select: NUM_IN=3, SELECT=3 -> RESULT=input 2, SEL_ERR=1 for that entry only.
REQ-033 SHALL cover flush priority: state FULL with FLUSH=1, IN_VALID=1 and OUT_READY=1 in the same cycle -> OCC=0, OUT_VALID=0, next cycle IN_READY=1.
REQ-034 SHALL cover async reset: assert RESET=0 mid-cycle while OCC=2 -> OCC=0, OUT_VALID=0 and RESULT=0 before the next CLK edge.
REQ-035 SHALL cover streaming: 100 random offers with random OUT_READY -> scoreboard shows exact in-order match, and throughput is 1 per cycle while OUT_READY=1.
